ifu: RTL

- Instruction fetch unit directly upstream of the integer execution unit in the sample processor.
- Owns the architectural PC and issues one instruction-memory request at a time over a request/ready/response handshake.
- Presents PC, PCPlus4 and Instr with a valid flag to the execution unit.
- Consumes the execution unit's PCSrc/IEUAdr redirect to select the next PC.

---
 rtl/ifu_pkg.sv | 14 +
 rtl/ifu.sv | 103 ++++++++++
 2 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    VALID,
    FAULT
  } ifu_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory request
// at a time and presents the fetched word to the execution unit.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] IEUAdr,
  input  logic        Stall,
  output logic        ImemReq,
  output logic [31:0] ImemAdr,
  input  logic        ImemReady,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic        FetchFault
);

  ifu_state_t  state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        req_q;
  logic        valid_q;
  logic        fault_q;
  logic [31:0] next_pc;
  logic        misaligned;

  // Wraps silently at the top of the address space.
  assign PCPlus4    = pc_q + 32'd4;
  assign next_pc    = PCSrc ? IEUAdr : PCPlus4;
  assign misaligned = PCSrc && (IEUAdr[1:0] != 2'b00);

  assign PC         = pc_q;
  assign ImemAdr    = pc_q;
  assign ImemReq    = req_q;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign FetchFault = fault_q;

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // mixing in blocking assignments would make the update order matter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      pc_q    <= RESET_VEC;
      instr_q <= NOP_INSTR;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          // Request stays up with a stable address until memory takes it.
          if (ImemReady) begin
            state <= WAIT;
            req_q <= 1'b0;
          end
        end
        WAIT: begin
          if (ImemRspValid) begin
            instr_q <= ImemRspData;
            valid_q <= 1'b1;
            state   <= VALID;
          end
        end
        VALID: begin
          // Stall freezes the instruction; a pending redirect is taken later.
          if (!Stall) begin
            pc_q    <= next_pc;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            if (misaligned) begin
              fault_q <= 1'b1;
              state   <= FAULT;
            end else begin
              req_q <= 1'b1;
              state <= FETCH;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state   <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
